// File: rtl/regfile_pkg.sv
// Shared constants and types for the 2-read / 1-write register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam logic [ADDR_W_DEF-1:0] ZERO_ADDR = '0;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_2r1w_if.sv
// Decode-stage register file bus: two read addresses, one write port, two read results.
interface regfile_2r1w_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_w_data;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  modport master (
    output rs_addr, rt_addr, rd_addr, rd_w_data,
    input  rs_data, rt_data
  );

  modport slave (
    input  rs_addr, rt_addr, rd_addr, rd_w_data,
    output rs_data, rt_data
  );

endinterface

// File: rtl/regfile_2r1w_read_port.sv
// One combinational read port: zero-register forcing, write-through bypass, array lookup.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] mem [2**ADDR_W],
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic [DATA_W-1:0] data
);

  logic is_zero;
  logic hit;

  assign is_zero = ZERO_REG && (addr == ADDR_W'(ZERO_ADDR));
  // wr_valid is low during reset, so a pending write never leaks to the outputs then
  assign hit     = BYPASS && wr_valid && (addr == wr_addr);

  // Priority: register 0 wins over bypass, bypass wins over stored contents
  always_comb begin
    data = mem[addr];
    if (is_zero) begin
      data = '0;
    end else if (hit) begin
      data = wr_data;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// MIPS-style register file: storage array with unconditional write every edge, two read ports.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_2r1w_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_discard;

  // No write enable exists; callers park rd_addr at 0 to suppress a write
  assign wr_discard = ZERO_REG && (bus.rd_addr == ADDR_W'(ZERO_ADDR));

  // Async clear of the whole array, otherwise store rd_w_data at rd_addr every edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (!wr_discard) begin
      mem[bus.rd_addr] <= bus.rd_w_data;
    end
  end

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_rs_port (
    .addr    (bus.rs_addr),
    .mem     (mem),
    .wr_addr (bus.rd_addr),
    .wr_data (bus.rd_w_data),
    .wr_valid(rst),
    .data    (bus.rs_data)
  );

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_rt_port (
    .addr    (bus.rt_addr),
    .mem     (mem),
    .wr_addr (bus.rd_addr),
    .wr_data (bus.rd_w_data),
    .wr_valid(rst),
    .data    (bus.rt_data)
  );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench: one bypassing and one non-bypassing instance driven in lockstep.
module tb_regfile_2r1w;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs_a, rt_a, rd_a;
  logic [31:0] wd;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       name;
    logic [31:0] b_rs;
    logic [31:0] b_rt;
    logic [31:0] n_rs;
    logic [31:0] n_rt;
  } exp_t;

  exp_t exp_q[$];
  event smp;

  regfile_2r1w_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();
  regfile_2r1w_if #(.DATA_W(32), .ADDR_W(5)) bus_n ();

  assign bus_b.rs_addr   = rs_a;
  assign bus_b.rt_addr   = rt_a;
  assign bus_b.rd_addr   = rd_a;
  assign bus_b.rd_w_data = wd;
  assign bus_n.rs_addr   = rs_a;
  assign bus_n.rt_addr   = rt_a;
  assign bus_n.rd_addr   = rd_a;
  assign bus_n.rd_w_data = wd;

  regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst_n), .bus(bus_b)
  );

  regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_n (
    .clk(clk), .rst(rst_n), .bus(bus_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic void cmp(string nm, string port, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s %s: got %h, required %h", nm, port, act, exp);
    end
  endfunction

  // Monitor: whenever outputs are strobed, drain the scoreboard against both instances
  initial begin
    exp_t e;
    forever begin
      @(smp);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp(e.name, "byp.rs", bus_b.rs_data, e.b_rs);
        cmp(e.name, "byp.rt", bus_b.rt_data, e.b_rt);
        cmp(e.name, "nob.rs", bus_n.rs_data, e.n_rs);
        cmp(e.name, "nob.rt", bus_n.rt_data, e.n_rt);
      end
    end
  end

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] d);
    rs_a = rs;
    rt_a = rt;
    rd_a = rd;
    wd   = d;
  endtask

  task automatic expect_out(input string nm, input logic [31:0] brs, input logic [31:0] brt,
                            input logic [31:0] nrs, input logic [31:0] nrt);
    exp_t e;
    #2;
    e.name = nm;
    e.b_rs = brs;
    e.b_rt = brt;
    e.n_rs = nrs;
    e.n_rt = nrt;
    exp_q.push_back(e);
    -> smp;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] v;
    rst_n = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 32'h0);
    #1;

    // Held in reset: every address reads 0, a matching rd_addr must not bypass
    for (int i = 0; i < 32; i++) begin
      drive(5'(i), 5'(31 - i), 5'(i), 32'hFFFF_0000 | 32'(i));
      expect_out("reset_read", 32'h0, 32'h0, 32'h0, 32'h0);
    end

    drive(5'd0, 5'd0, 5'd0, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Write/read sweep: bypass sees the value before the edge, non-bypass after it
    for (int i = 0; i < 10; i++) begin
      v = 32'(i);
      drive(5'(i), 5'(i), 5'(i), v);
      expect_out("sweep_pre", v, v, 32'h0, 32'h0);
      tick();
      drive(5'(i), 5'(i), 5'd0, 32'h0);
      expect_out("sweep_post", v, v, v, v);
      tick();
    end

    // Register 0 ignores writes and never bypasses
    drive(5'd0, 5'd0, 5'd0, 32'hDEAD_BEEF);
    expect_out("zero_pre", 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    drive(5'd0, 5'd0, 5'd0, 32'h0);
    expect_out("zero_post", 32'h0, 32'h0, 32'h0, 32'h0);

    // Dual-port independence and combinational swap
    drive(5'd0, 5'd0, 5'd5, 32'h55);
    tick();
    drive(5'd0, 5'd0, 5'd7, 32'h77);
    tick();
    drive(5'd5, 5'd7, 5'd0, 32'h0);
    expect_out("dual", 32'h55, 32'h77, 32'h55, 32'h77);
    drive(5'd7, 5'd5, 5'd0, 32'h0);
    expect_out("dual_swap", 32'h77, 32'h55, 32'h77, 32'h55);
    tick();

    // Both ports on the address being written
    drive(5'd12, 5'd12, 5'd12, 32'hC0C0);
    expect_out("both_byp", 32'hC0C0, 32'hC0C0, 32'h0, 32'h0);
    tick();
    drive(5'd12, 5'd12, 5'd0, 32'h0);
    expect_out("both_post", 32'hC0C0, 32'hC0C0, 32'hC0C0, 32'hC0C0);
    tick();

    // Overwrite on consecutive edges
    drive(5'd3, 5'd3, 5'd3, 32'hA);
    tick();
    drive(5'd3, 5'd3, 5'd3, 32'hB);
    expect_out("overwrite_pre", 32'hB, 32'hB, 32'hA, 32'hA);
    tick();
    drive(5'd3, 5'd3, 5'd0, 32'h0);
    expect_out("overwrite_post", 32'hB, 32'hB, 32'hB, 32'hB);
    tick();

    // Full address range
    drive(5'd0, 5'd0, 5'd31, 32'hFFFF_FFFF);
    tick();
    drive(5'd0, 5'd0, 5'd1, 32'h1);
    tick();
    drive(5'd31, 5'd1, 5'd0, 32'h0);
    expect_out("range_31_1", 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h1);
    drive(5'd30, 5'd31, 5'd0, 32'h0);
    expect_out("range_30_31", 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF);
    tick();
    drive(5'd31, 5'd1, 5'd30, 32'h1234);
    expect_out("byp_miss", 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h1);
    drive(5'd30, 5'd1, 5'd30, 32'h1234);
    expect_out("byp_hit30", 32'h1234, 32'h1, 32'h0, 32'h1);
    tick();
    drive(5'd30, 5'd1, 5'd0, 32'h0);
    expect_out("r30_post", 32'h1234, 32'h1, 32'h1234, 32'h1);
    tick();

    // Mid-run reset: outputs clear with no clock edge in between
    drive(5'd5, 5'd31, 5'd0, 32'h0);
    rst_n = 1'b0;
    expect_out("midrst", 32'h0, 32'h0, 32'h0, 32'h0);
    drive(5'd5, 5'd31, 5'd5, 32'h99);
    expect_out("midrst_byp", 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    drive(5'd5, 5'd31, 5'd0, 32'h0);
    expect_out("midrst_blocked", 32'h0, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b1;
    tick();
    expect_out("after_release", 32'h0, 32'h0, 32'h0, 32'h0);

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
      #1;
    end
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
